// File: rtl/cpu_phase_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/WB control sequencer with memory-wait stretching,
// halt handling, a stall watchdog and saturating retire/stall counters.
module cpu_phase_sequencer #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_start,
  input  logic             i_halt_req,
  input  logic             i_mem_ready,
  input  logic             i_exec_mem,
  input  logic             i_is_halt,
  output logic             o_fetch_req,
  output logic             o_ir_we,
  output logic             o_exec_en,
  output logic             o_dmem_req,
  output logic             o_rf_we,
  output logic             o_pc_we,
  output logic [1:0]       o_phase,
  output logic             o_busy,
  output logic             o_halted,
  output logic             o_timeout_err,
  output logic [CNT_W-1:0] o_instr_count,
  output logic [CNT_W-1:0] o_stall_count
);

  localparam int WCNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WCNT_W-1:0] TMO = WCNT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT,
    S_ERR
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              halt_lat;
  logic [WCNT_W-1:0] wcnt;
  logic [CNT_W-1:0]  instr_cnt;
  logic [CNT_W-1:0]  stall_cnt;
  logic              stall;
  logic              tmo_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // With TIMEOUT == 0 the watchdog never fires and the wait counter parks at 0.
  assign tmo_hit = (TIMEOUT != 0) && (wcnt == TMO);

  always_comb begin
    state_nxt     = state;
    stall         = 1'b0;
    o_fetch_req   = 1'b0;
    o_ir_we       = 1'b0;
    o_exec_en     = 1'b0;
    o_dmem_req    = 1'b0;
    o_rf_we       = 1'b0;
    o_pc_we       = 1'b0;
    o_phase       = 2'd0;
    o_busy        = 1'b0;
    o_halted      = 1'b0;
    o_timeout_err = 1'b0;
    case (state)
      S_IDLE: begin
        if (halt_lat || i_halt_req) state_nxt = S_HALT;
        else if (i_start)           state_nxt = S_FETCH;
      end
      S_FETCH: begin
        o_busy      = 1'b1;
        o_phase     = 2'd0;
        o_fetch_req = 1'b1;
        if (i_mem_ready) begin
          o_ir_we   = 1'b1;
          state_nxt = S_DECODE;
        end else begin
          stall = 1'b1;
          if (tmo_hit) state_nxt = S_ERR;
        end
      end
      S_DECODE: begin
        o_busy    = 1'b1;
        o_phase   = 2'd1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        o_busy    = 1'b1;
        o_phase   = 2'd2;
        o_exec_en = 1'b1;
        if (!i_exec_mem) begin
          state_nxt = S_WB;
        end else begin
          o_dmem_req = 1'b1;
          if (i_mem_ready) begin
            state_nxt = S_WB;
          end else begin
            stall = 1'b1;
            if (tmo_hit) state_nxt = S_ERR;
          end
        end
      end
      S_WB: begin
        o_busy    = 1'b1;
        o_phase   = 2'd3;
        o_rf_we   = 1'b1;
        o_pc_we   = 1'b1;
        state_nxt = (i_is_halt || halt_lat) ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        o_halted = 1'b1;
        if (i_start) state_nxt = S_FETCH;
      end
      S_ERR: begin
        o_timeout_err = 1'b1;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      halt_lat <= 1'b0;
      wcnt     <= '0;
    end else begin
      state <= state_nxt;
      // A pending halt request is consumed by the transition into HALT.
      if (state_nxt == S_HALT && state != S_HALT) halt_lat <= 1'b0;
      else if (i_halt_req)                        halt_lat <= 1'b1;
      if (state_nxt != state)         wcnt <= '0;
      else if (stall && wcnt != TMO)  wcnt <= wcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (state == S_WB) instr_cnt <= sat_inc(instr_cnt);
      if (stall)         stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign o_instr_count = instr_cnt;
  assign o_stall_count = stall_cnt;

endmodule

// File: tb/tb_cpu_phase_sequencer.sv
// Directed bench for cpu_phase_sequencer: a default instance plus a small
// instance (3-bit counters, TIMEOUT=4) driven by the same inputs.
module tb_cpu_phase_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  logic i_start, i_halt_req, i_mem_ready, i_exec_mem, i_is_halt;

  logic        fetch_req, ir_we, exec_en, dmem_req, rf_we, pc_we, busy, halted, terr;
  logic [1:0]  phase;
  logic [31:0] icnt, scnt;

  logic        t_fetch_req, t_ir_we, t_exec_en, t_dmem_req, t_rf_we, t_pc_we, t_busy, t_halted, t_terr;
  logic [1:0]  t_phase;
  logic [2:0]  t_icnt, t_scnt;

  logic [10:0] outv, t_outv;
  logic [5:0]  st, t_st;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cpu_phase_sequencer dut (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_halt_req(i_halt_req),
    .i_mem_ready(i_mem_ready), .i_exec_mem(i_exec_mem), .i_is_halt(i_is_halt),
    .o_fetch_req(fetch_req), .o_ir_we(ir_we), .o_exec_en(exec_en), .o_dmem_req(dmem_req),
    .o_rf_we(rf_we), .o_pc_we(pc_we), .o_phase(phase), .o_busy(busy), .o_halted(halted),
    .o_timeout_err(terr), .o_instr_count(icnt), .o_stall_count(scnt)
  );

  cpu_phase_sequencer #(.CNT_W(3), .TIMEOUT(4)) dut_t (
    .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_halt_req(i_halt_req),
    .i_mem_ready(i_mem_ready), .i_exec_mem(i_exec_mem), .i_is_halt(i_is_halt),
    .o_fetch_req(t_fetch_req), .o_ir_we(t_ir_we), .o_exec_en(t_exec_en), .o_dmem_req(t_dmem_req),
    .o_rf_we(t_rf_we), .o_pc_we(t_pc_we), .o_phase(t_phase), .o_busy(t_busy), .o_halted(t_halted),
    .o_timeout_err(t_terr), .o_instr_count(t_icnt), .o_stall_count(t_scnt)
  );

  assign st     = {fetch_req, ir_we, exec_en, dmem_req, rf_we, pc_we};
  assign t_st   = {t_fetch_req, t_ir_we, t_exec_en, t_dmem_req, t_rf_we, t_pc_we};
  assign outv   = {st, busy, phase, halted, terr};
  assign t_outv = {t_st, t_busy, t_phase, t_halted, t_terr};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_start = 1'b0; i_halt_req = 1'b0; i_mem_ready = 1'b0; i_exec_mem = 1'b0; i_is_halt = 1'b0;
    #2;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_start = 1'b0; i_halt_req = 1'b0; i_mem_ready = 1'b0; i_exec_mem = 1'b0; i_is_halt = 1'b0;
    #3;
    vectors++; if (outv !== 11'd0) begin miscompares++; $display("FAIL reset_outputs: got %h expected 000", outv); end
    vectors++; if ({icnt, scnt} !== 64'd0) begin miscompares++; $display("FAIL reset_counts: got %0d/%0d expected 0/0", icnt, scnt); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    #2;
    vectors++; if (outv !== 11'd0) begin miscompares++; $display("FAIL reset_idle: got %h expected 000", outv); end
  endtask

  task automatic test_basic();
    logic [5:0] exp_st;
    do_reset();
    i_mem_ready = 1'b1; i_exec_mem = 1'b0; i_is_halt = 1'b0; i_start = 1'b1;
    #2;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL basic_idle_busy: got %b expected 0", busy); end
    step();
    i_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      for (int ph = 0; ph < 4; ph++) begin
        #2;
        case (ph)
          0:       exp_st = 6'b110000;
          2:       exp_st = 6'b001000;
          3:       exp_st = 6'b000011;
          default: exp_st = 6'b000000;
        endcase
        vectors++; if ({busy, phase} !== {1'b1, 2'(ph)}) begin miscompares++; $display("FAIL basic_phase i%0d: got %b expected %b", i, {busy, phase}, {1'b1, 2'(ph)}); end
        vectors++; if (st !== exp_st) begin miscompares++; $display("FAIL basic_strobes i%0d ph%0d: got %b expected %b", i, ph, st, exp_st); end
        step();
      end
    end
    #2;
    vectors++; if (icnt !== 32'd10) begin miscompares++; $display("FAIL basic_icnt: got %0d expected 10", icnt); end
    vectors++; if (scnt !== 32'd0) begin miscompares++; $display("FAIL basic_scnt: got %0d expected 0", scnt); end
    vectors++; if (t_icnt !== 3'd7) begin miscompares++; $display("FAIL basic_icnt_saturate: got %0d expected 7", t_icnt); end
  endtask

  task automatic test_stall();
    int         ph_t [9] = '{0, 0, 0, 0, 1, 2, 2, 2, 3};
    logic       rdy_t [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       em_t [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [5:0] st_t [9] = '{6'b100000, 6'b100000, 6'b100000, 6'b110000, 6'b000000,
                             6'b001100, 6'b001100, 6'b001100, 6'b000011};
    int ir_cycles = 0;
    int dmem_rises = 0;
    logic dmem_prev = 1'b0;
    do_reset();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 0; c < 9; c++) begin
      i_mem_ready = rdy_t[c];
      i_exec_mem  = em_t[c];
      #2;
      vectors++; if ({busy, phase} !== {1'b1, 2'(ph_t[c])}) begin miscompares++; $display("FAIL stall_phase c%0d: got %b expected %b", c, {busy, phase}, {1'b1, 2'(ph_t[c])}); end
      vectors++; if (st !== st_t[c]) begin miscompares++; $display("FAIL stall_strobes c%0d: got %b expected %b", c, st, st_t[c]); end
      if (ir_we) ir_cycles++;
      if (dmem_req && !dmem_prev) dmem_rises++;
      dmem_prev = dmem_req;
      step();
    end
    i_mem_ready = 1'b0; i_exec_mem = 1'b0;
    #2;
    vectors++; if ({busy, phase, fetch_req} !== 4'b1001) begin miscompares++; $display("FAIL stall_nine_clocks: got %b expected 1001", {busy, phase, fetch_req}); end
    vectors++; if (scnt !== 32'd5) begin miscompares++; $display("FAIL stall_scnt: got %0d expected 5", scnt); end
    vectors++; if (t_scnt !== 3'd5) begin miscompares++; $display("FAIL stall_t_scnt: got %0d expected 5", t_scnt); end
    vectors++; if (icnt !== 32'd1) begin miscompares++; $display("FAIL stall_icnt: got %0d expected 1", icnt); end
    vectors++; if (ir_cycles !== 1) begin miscompares++; $display("FAIL stall_ir_we_pulses: got %0d expected 1", ir_cycles); end
    vectors++; if (dmem_rises !== 1) begin miscompares++; $display("FAIL stall_dmem_pulses: got %0d expected 1", dmem_rises); end
  endtask

  task automatic test_halt_instr();
    do_reset();
    i_mem_ready = 1'b1; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 0; c < 12; c++) begin
      i_is_halt = (c == 11);
      #2;
      if (c == 11) begin
        vectors++; if (phase !== 2'd3) begin miscompares++; $display("FAIL haltinstr_wb: got %0d expected 3", phase); end
      end
      step();
    end
    i_is_halt = 1'b0;
    #2;
    vectors++; if ({busy, phase, halted} !== 4'b0001) begin miscompares++; $display("FAIL haltinstr_halted: got %b expected 0001", {busy, phase, halted}); end
    vectors++; if (icnt !== 32'd3) begin miscompares++; $display("FAIL haltinstr_icnt: got %0d expected 3", icnt); end
    step();
    #2;
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL haltinstr_hold: got %b expected 1", halted); end
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    #2;
    vectors++; if ({busy, phase, fetch_req, halted} !== 5'b10010) begin miscompares++; $display("FAIL haltinstr_resume: got %b expected 10010", {busy, phase, fetch_req, halted}); end
    for (int c = 0; c < 4; c++) step();
    #2;
    vectors++; if (icnt !== 32'd4) begin miscompares++; $display("FAIL haltinstr_icnt_cont: got %0d expected 4", icnt); end
  endtask

  task automatic test_halt_req();
    do_reset();
    i_mem_ready = 1'b1; i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    #2;
    vectors++; if (phase !== 2'd1) begin miscompares++; $display("FAIL haltreq_decode: got %0d expected 1", phase); end
    i_halt_req = 1'b1;
    step();
    i_halt_req = 1'b0;
    step();
    #2;
    vectors++; if ({phase, rf_we, pc_we} !== 4'b1111) begin miscompares++; $display("FAIL haltreq_wb_completes: got %b expected 1111", {phase, rf_we, pc_we}); end
    step();
    #2;
    vectors++; if ({busy, halted} !== 2'b01) begin miscompares++; $display("FAIL haltreq_halted: got %b expected 01", {busy, halted}); end
    vectors++; if (icnt !== 32'd1) begin miscompares++; $display("FAIL haltreq_icnt: got %0d expected 1", icnt); end
    do_reset();
    i_mem_ready = 1'b1; i_start = 1'b1; i_halt_req = 1'b1;
    step();
    i_start = 1'b0; i_halt_req = 1'b0;
    #2;
    vectors++; if ({busy, halted} !== 2'b01) begin miscompares++; $display("FAIL haltreq_idle_priority: got %b expected 01", {busy, halted}); end
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 0; c < 4; c++) step();
    #2;
    vectors++; if ({busy, phase, halted} !== 4'b1000) begin miscompares++; $display("FAIL haltreq_latch_cleared: got %b expected 1000", {busy, phase, halted}); end
  endtask

  task automatic test_timeout();
    do_reset();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #2;
      vectors++; if ({t_fetch_req, t_terr} !== 2'b10) begin miscompares++; $display("FAIL timeout_wait c%0d: got %b expected 10", c, {t_fetch_req, t_terr}); end
      step();
    end
    #2;
    vectors++; if (t_outv !== 11'b000000_0_00_0_1) begin miscompares++; $display("FAIL timeout_err_state: got %b expected 00000000001", t_outv); end
    vectors++; if ({fetch_req, terr} !== 2'b10) begin miscompares++; $display("FAIL timeout_default_still_waiting: got %b expected 10", {fetch_req, terr}); end
    i_mem_ready = 1'b1;
    #1;
    vectors++; if (t_st !== 6'd0) begin miscompares++; $display("FAIL timeout_no_strobes: got %b expected 000000", t_st); end
    step();
    #2;
    vectors++; if ({t_busy, t_terr} !== 2'b01) begin miscompares++; $display("FAIL timeout_sticky: got %b expected 01", {t_busy, t_terr}); end
    do_reset();
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 0; c < 5; c++) begin
      i_mem_ready = (c == 4);
      #2;
      if (c == 4) begin
        vectors++; if (t_ir_we !== 1'b1) begin miscompares++; $display("FAIL timeout_ready_wins_irwe: got %b expected 1", t_ir_we); end
      end
      step();
    end
    #2;
    vectors++; if ({t_busy, t_phase, t_terr} !== 4'b1010) begin miscompares++; $display("FAIL timeout_ready_wins_decode: got %b expected 1010", {t_busy, t_phase, t_terr}); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_mem_ready = 1'b1; i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int c = 0; c < 4; c++) step();
    step();
    i_exec_mem = 1'b1; i_mem_ready = 1'b0;
    step();
    #2;
    vectors++; if ({phase, exec_en, dmem_req} !== 4'b1011) begin miscompares++; $display("FAIL rstmid_exec: got %b expected 1011", {phase, exec_en, dmem_req}); end
    vectors++; if (icnt !== 32'd1) begin miscompares++; $display("FAIL rstmid_icnt_before: got %0d expected 1", icnt); end
    rst_n = 1'b0;
    #1;
    vectors++; if ({outv, t_outv} !== 22'd0) begin miscompares++; $display("FAIL rstmid_async_outputs: got %h expected 0", {outv, t_outv}); end
    vectors++; if ({icnt, scnt} !== 64'd0) begin miscompares++; $display("FAIL rstmid_counts: got %0d/%0d expected 0/0", icnt, scnt); end
    #1;
    rst_n = 1'b1;
    i_exec_mem = 1'b0;
    step();
    #2;
    vectors++; if (outv !== 11'd0) begin miscompares++; $display("FAIL rstmid_idle: got %b expected 0", outv); end
    vectors++; if ({icnt, scnt} !== 64'd0) begin miscompares++; $display("FAIL rstmid_counts_after: got %0d/%0d expected 0/0", icnt, scnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_halt_instr();
    test_halt_req();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/cpu_phase_sequencer.md
Name: cpu_phase_sequencer

Overview:
- Multi-cycle control sequencer for the CPU core.
- Steps each instruction through FETCH, DECODE, EXEC and WB, so a zero-stall instruction takes exactly 4 clocks.
- Stretches the FETCH and EXEC phases while instruction or data memory (including UART-mapped I/O) is not ready.
- Provides halt and stall-timeout control, plus instruction and stall counters that the bench reads for cycle accounting.

Parameters:
- CNT_W, 32, width of o_instr_count and o_stall_count.
- TIMEOUT, 255, maximum consecutive wait cycles in FETCH or EXEC before the ERR state. 0 disables the timeout.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  start or resume pulse; honoured only in IDLE or HALT.
- i_halt_req  in  1  external halt request; latched in a sticky bit.
- i_mem_ready  in  1  memory/IO acknowledge for the current o_fetch_req or o_dmem_req.
- i_exec_mem  in  1  decoded instruction needs a data-memory/IO access; sampled in EXEC.
- i_is_halt  in  1  decoded instruction is HALT; sampled in WB.
- o_fetch_req  out  1  instruction fetch request.
- o_ir_we  out  1  instruction register write enable.
- o_exec_en  out  1  ALU/execute enable.
- o_dmem_req  out  1  data-memory/IO request.
- o_rf_we  out  1  register-file write enable.
- o_pc_we  out  1  PC update enable.
- o_phase  out  2  current phase: 0 FETCH, 1 DECODE, 2 EXEC, 3 WB.
- o_busy  out  1  sequencer is in FETCH, DECODE, EXEC or WB.
- o_halted  out  1  sequencer is in HALT.
- o_timeout_err  out  1  sequencer is in ERR.
- o_instr_count  out  CNT_W  retired instructions, saturating.
- o_stall_count  out  CNT_W  total wait cycles, saturating.

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT, ERR. State is registered; all strobe outputs are Moore/Mealy combinational as specified below.
- Reset (async, rst_n=0) forces:
  - state=IDLE;
  - halt latch, wait counter, both counters = 0;
  - every output = 0.
- Halt latch:
  - Set when i_halt_req=1.
  - Cleared on entry to HALT.
- IDLE:
  - If the halt latch or i_halt_req is set, go to HALT. Halt wins over a simultaneous i_start.
  - Else if i_start, go to FETCH.
- FETCH:
  - o_fetch_req=1.
  - If i_mem_ready: o_ir_we=1 in that same cycle, then go to DECODE.
  - Else: stay; increment the wait counter and o_stall_count.
- DECODE: exactly 1 cycle, then go to EXEC.
- EXEC:
  - o_exec_en=1.
  - If i_exec_mem=0: go to WB next cycle.
  - If i_exec_mem=1: o_dmem_req=1. Go to WB on i_mem_ready; otherwise stall exactly as in FETCH.
- WB:
  - o_rf_we=1 and o_pc_we=1 for 1 cycle.
  - o_instr_count increments by 1, holding at all-ones.
  - Next state: HALT if i_is_halt or the halt latch is set; otherwise FETCH.
- HALT:
  - o_halted=1.
  - i_start goes to FETCH. Counters are preserved, not cleared.
- ERR:
  - o_timeout_err=1; no strobes are driven.
  - Exit only by reset.
- Timeout:
  - The wait counter clears on every state entry and is $clog2(TIMEOUT+1) bits wide.
  - Go to ERR when the wait counter == TIMEOUT and i_mem_ready=0 in FETCH or EXEC.
  - If i_mem_ready=1 in that same cycle, the ready wins and the sequencer proceeds normally.
- o_phase is 0 and o_busy is 0 in IDLE, HALT and ERR.
- i_start while busy is ignored; it does not queue.
- i_halt_req mid-instruction never aborts the instruction. It takes effect at the next WB, after retirement.
- o_stall_count saturates at all-ones.
- Reset asserted mid-instruction: immediate return to IDLE. No strobe may be asserted during reset.

Test Plan:
- Reset, then i_start pulse; i_mem_ready tied 1, i_exec_mem=0, i_is_halt=0 -> o_phase cycles 0,1,2,3 every 4 clocks. After 10 instructions (40 clocks), o_instr_count=10 and o_stall_count=0.
- i_mem_ready held 0 for 3 cycles in FETCH and 2 cycles in an EXEC with i_exec_mem=1 -> that instruction takes 9 clocks. o_stall_count=5, and o_ir_we and o_dmem_req each pulse exactly once.
- i_is_halt=1 during the WB of instruction 3 -> o_halted=1 on the next cycle with o_instr_count=3. Then i_start -> FETCH resumes and o_instr_count continues from 4.
- i_halt_req pulsed during DECODE -> the instruction completes its WB, then HALT. A simultaneous i_start and i_halt_req in IDLE -> HALT.
- TIMEOUT=4, i_mem_ready=0 in FETCH -> ERR entered after the 5th wait cycle, with o_timeout_err=1 and no strobes. A second run with i_mem_ready=1 on wait cycle 4 -> proceeds to DECODE with no error.
- rst_n dropped during EXEC -> all outputs go to 0 immediately (asynchronously). After release, state is IDLE and both counters are 0.
